kem_step_sequencer: RTL and testbench

- Parametrised, table-driven sequencer that replaces the hard-coded per-function KEM FSMs.
- One block drives any number of datapath modules (TRNG, sampler, NTT, ...). For each of N_MODE functions (keygen/encap/decap), it runs a programmable list of steps.
- Each step launches one module a programmable number of times, with a run/done handshake and a timeout.
- Sits between the KEM top-level control and the datapath modules. It emits single-cycle run pulses and level enables.

---
 rtl/kem_step_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_kem_step_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/kem_step_sequencer.sv
// rtl/kem_step_sequencer.sv - table-driven step sequencer for KEM datapath modules
// Each mode runs a programmable list of {last, mod_sel, rep} steps with run/done handshakes.
module kem_step_sequencer #(
  parameter int N_MOD   = 3,
  parameter int N_STEP  = 16,
  parameter int N_MODE  = 3,
  parameter int REP_W   = 8,
  parameter int TIMEOUT = 4096,
  localparam int AW     = $clog2(N_STEP),
  localparam int MS_W   = (N_MOD > 1) ? $clog2(N_MOD) : 1,
  localparam int SW     = 1 + MS_W + REP_W
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              run_i,
  input  logic [N_MODE-1:0] mode_i,
  input  logic              abort_i,
  input  logic              prog_we_i,
  input  logic              prog_tbl_i,
  input  logic [AW-1:0]     prog_addr_i,
  input  logic [SW-1:0]     prog_data_i,
  output logic [N_MOD-1:0]  mod_run_o,
  output logic [N_MOD-1:0]  mod_en_o,
  input  logic [N_MOD-1:0]  mod_done_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [AW-1:0]     step_o
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_LAUNCH, S_WAIT, S_NEXT, S_DONE, S_ERR
  } state_t;

  state_t            state_q;
  logic [AW-1:0]     pc_q;
  logic [REP_W-1:0]  rep_q;
  logic [TW-1:0]     tmo_q;
  logic [AW:0]       steps_q;
  logic [MS_W-1:0]   sel_q;
  logic              last_q;
  logic [N_MOD-1:0]  en_q;
  logic [SW-1:0]     step_tbl_q  [N_STEP];
  logic [AW-1:0]     start_tbl_q [N_MODE];

  function automatic logic [N_MOD-1:0] sel_onehot(input logic [MS_W-1:0] s);
    logic [N_MOD-1:0] oh;
    oh = '0;
    for (int i = 0; i < N_MOD; i++) begin
      if (s == MS_W'(i)) oh[i] = 1'b1;
    end
    return oh;
  endfunction

  logic [SW-1:0]     cur_word;
  logic              word_last;
  logic [MS_W-1:0]   word_sel;
  logic [REP_W-1:0]  word_rep;
  logic [N_MOD-1:0]  word_oh;
  logic [N_MOD-1:0]  sel_oh;
  logic              sel_done;
  logic              tmo_hit;
  logic              tbl_open;

  assign cur_word  = step_tbl_q[pc_q];
  assign word_last = cur_word[SW-1];
  assign word_sel  = cur_word[REP_W +: MS_W];
  assign word_rep  = cur_word[REP_W-1:0];
  assign word_oh   = sel_onehot(word_sel);
  assign sel_oh    = sel_onehot(sel_q);
  assign sel_done  = |(mod_done_i & sel_oh);
  assign tmo_hit   = (TIMEOUT != 0) && (tmo_q == TW'(TIMEOUT - 1));
  assign tbl_open  = (state_q == S_IDLE) || (state_q == S_ERR);

  logic              mode_one;
  logic              mode_many;
  logic [AW-1:0]     start_sel;

  always_comb begin
    mode_one  = 1'b0;
    mode_many = 1'b0;
    start_sel = '0;
    for (int i = 0; i < N_MODE; i++) begin
      if (mode_i[i]) begin
        if (mode_one) mode_many = 1'b1;
        mode_one  = 1'b1;
        start_sel = start_tbl_q[i];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      rep_q   <= '0;
      tmo_q   <= '0;
      steps_q <= '0;
      sel_q   <= '0;
      last_q  <= 1'b0;
      en_q    <= '0;
      for (int i = 0; i < N_STEP; i++) step_tbl_q[i] <= '0;
      for (int i = 0; i < N_MODE; i++) start_tbl_q[i] <= '0;
    end else begin
      if (prog_we_i && tbl_open) begin
        if (!prog_tbl_i) begin
          step_tbl_q[prog_addr_i] <= prog_data_i;
        end else begin
          for (int i = 0; i < N_MODE; i++) begin
            if (prog_addr_i == AW'(i)) start_tbl_q[i] <= prog_data_i[AW-1:0];
          end
        end
      end

      en_q <= '0;
      if (abort_i) begin
        state_q <= S_IDLE;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (run_i) begin
              if (mode_one && !mode_many) begin
                pc_q    <= start_sel;
                steps_q <= '0;
                state_q <= S_FETCH;
              end else begin
                state_q <= S_ERR;
              end
            end
          end
          S_FETCH: begin
            sel_q  <= word_sel;
            last_q <= word_last;
            rep_q  <= word_rep;
            if (word_oh == '0) begin
              state_q <= S_ERR;
            end else if (word_rep == '0) begin
              state_q <= S_NEXT;
            end else begin
              en_q    <= word_oh;
              state_q <= S_LAUNCH;
            end
          end
          S_LAUNCH: begin
            tmo_q   <= '0;
            en_q    <= sel_oh;
            state_q <= S_WAIT;
          end
          S_WAIT: begin
            // done in the expiry cycle still counts as a completion
            if (sel_done) begin
              rep_q   <= rep_q - REP_W'(1);
              state_q <= (rep_q != REP_W'(1)) ? S_LAUNCH : S_NEXT;
            end else if (tmo_hit) begin
              state_q <= S_ERR;
            end else begin
              en_q  <= sel_oh;
              tmo_q <= tmo_q + TW'(1);
            end
          end
          S_NEXT: begin
            if (last_q) begin
              state_q <= S_DONE;
            end else begin
              pc_q    <= (pc_q == AW'(N_STEP - 1)) ? '0 : pc_q + AW'(1);
              steps_q <= steps_q + (AW+1)'(1);
              state_q <= (steps_q == (AW+1)'(N_STEP - 1)) ? S_ERR : S_FETCH;
            end
          end
          S_DONE:  state_q <= S_IDLE;
          S_ERR:   state_q <= S_ERR;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign mod_run_o = (state_q == S_LAUNCH) ? sel_oh : '0;
  assign mod_en_o  = en_q;
  assign busy_o    = (state_q != S_IDLE) && (state_q != S_ERR);
  assign done_o    = (state_q == S_DONE);
  assign err_o     = (state_q == S_ERR);
  assign step_o    = pc_q;

endmodule

// File: tb/tb_kem_step_sequencer.sv
// tb/tb_kem_step_sequencer.sv - self-checking bench for kem_step_sequencer
module tb_kem_step_sequencer;
  localparam int N_MOD = 3, N_STEP = 16, N_MODE = 3, REP_W = 8, TIMEOUT = 8;
  localparam int AW = 4, SW = 11;

  logic            clk = 1'b0;
  logic            rst_n_i;
  logic            run_i;
  logic [2:0]      mode_i;
  logic            abort_i;
  logic            prog_we_i;
  logic            prog_tbl_i;
  logic [AW-1:0]   prog_addr_i;
  logic [SW-1:0]   prog_data_i;
  logic [2:0]      mod_run_o;
  logic [2:0]      mod_en_o;
  logic [2:0]      mod_done_i;
  logic            busy_o;
  logic            done_o;
  logic            err_o;
  logic [AW-1:0]   step_o;

  kem_step_sequencer #(
    .N_MOD(N_MOD), .N_STEP(N_STEP), .N_MODE(N_MODE), .REP_W(REP_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n_i), .run_i(run_i), .mode_i(mode_i), .abort_i(abort_i),
    .prog_we_i(prog_we_i), .prog_tbl_i(prog_tbl_i), .prog_addr_i(prog_addr_i),
    .prog_data_i(prog_data_i), .mod_run_o(mod_run_o), .mod_en_o(mod_en_o),
    .mod_done_i(mod_done_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .step_o(step_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SW-1:0] sw(input logic last, input logic [1:0] sel, input logic [7:0] rep);
    return {last, sel, rep};
  endfunction

  task automatic do_reset();
    run_i = 1'b0; mode_i = '0; abort_i = 1'b0; prog_we_i = 1'b0; prog_tbl_i = 1'b0;
    prog_addr_i = '0; prog_data_i = '0; mod_done_i = '0;
    rst_n_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n_i = 1'b1;
    tick();
  endtask

  task automatic prog(input logic tbl, input logic [AW-1:0] addr, input logic [SW-1:0] data);
    prog_we_i = 1'b1; prog_tbl_i = tbl; prog_addr_i = addr; prog_data_i = data;
    tick();
    prog_we_i = 1'b0;
  endtask

  typedef struct {
    string         name;
    logic [SW-1:0] s0;
    logic [SW-1:0] s1;
    logic [SW-1:0] fill;
    logic [2:0]    mode;
    int            delay;
    logic [2:0]    noise;
    int            n_launch;
    logic [31:0]   launches;
    int            first_run;
    int            done_cyc;
    int            err_cyc;
    int            fin_step;
  } vec_t;

  vec_t vecs[9];

  task automatic run_vec(input vec_t v);
    int cyc, first_run, done_cyc, err_cyc, n_done, tail;
    int resp[N_MOD];
    bit fin;
    logic [1:0] e;
    logic [1:0] expq[$];
    do_reset();
    for (int a = 0; a < N_STEP; a++)
      prog(1'b0, 4'(a), (a == 0) ? v.s0 : (a == 1) ? v.s1 : v.fill);
    for (int m = 0; m < N_MODE; m++) prog(1'b1, 4'(m), '0);
    for (int i = 0; i < v.n_launch; i++) expq.push_back(v.launches[2*i +: 2]);
    for (int k = 0; k < N_MOD; k++) resp[k] = -1;
    first_run = -1; done_cyc = -1; err_cyc = -1; n_done = 0; tail = 0; fin = 1'b0;
    run_i = 1'b1; mode_i = v.mode;
    tick();
    run_i = 1'b0; mode_i = '0;
    cyc = 1;
    while (tail < 3 && cyc < 200) begin
      if (mod_run_o != 3'b000) begin
        if (first_run < 0) first_run = cyc;
        if (expq.size() == 0) begin
          check({v.name, ".extra_launch"}, 32'(mod_run_o), 32'd0);
        end else begin
          e = expq.pop_front();
          check({v.name, ".launch"}, 32'(mod_run_o), 32'(3'b001 << e));
        end
        for (int k = 0; k < N_MOD; k++)
          if (mod_run_o[k] && v.delay > 0) resp[k] = cyc + v.delay;
      end
      if (done_o) begin
        n_done++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (err_o && err_cyc < 0) err_cyc = cyc;
      if (done_o || err_o) fin = 1'b1;
      if (fin) tail++;
      for (int k = 0; k < N_MOD; k++) mod_done_i[k] = (resp[k] == cyc) || v.noise[k];
      tick();
      cyc++;
    end
    mod_done_i = '0;
    check({v.name, ".terminated"}, 32'(fin), 32'd1);
    check({v.name, ".first_run_cycle"}, first_run, v.first_run);
    check({v.name, ".done_cycle"}, done_cyc, v.done_cyc);
    check({v.name, ".done_count"}, n_done, (v.done_cyc >= 0) ? 1 : 0);
    check({v.name, ".err_cycle"}, err_cyc, v.err_cyc);
    check({v.name, ".missing_launches"}, expq.size(), 0);
    check({v.name, ".step"}, 32'(step_o), v.fin_step);
    check({v.name, ".busy_end"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    logic [2:0] en_exp [6];
    logic [2:0] run_exp[6];
    int cyc;
    bit saw_run;

    vecs[0] = '{name:"basic", s0:sw(1'b0,2'd2,8'd2), s1:sw(1'b1,2'd0,8'd1), fill:'0, mode:3'b001,
                delay:5, noise:3'b010, n_launch:3, launches:32'h0000_000A,
                first_run:2, done_cyc:23, err_cyc:-1, fin_step:1};
    vecs[1] = '{name:"noop_first", s0:sw(1'b0,2'd0,8'd0), s1:sw(1'b1,2'd1,8'd1), fill:'0, mode:3'b001,
                delay:5, noise:3'b000, n_launch:1, launches:32'h0000_0001,
                first_run:4, done_cyc:11, err_cyc:-1, fin_step:1};
    vecs[2] = '{name:"mode_two_hot", s0:sw(1'b1,2'd0,8'd1), s1:'0, fill:'0, mode:3'b011,
                delay:1, noise:3'b000, n_launch:0, launches:32'h0,
                first_run:-1, done_cyc:-1, err_cyc:1, fin_step:0};
    vecs[3] = '{name:"mode_zero", s0:sw(1'b1,2'd0,8'd1), s1:'0, fill:'0, mode:3'b000,
                delay:1, noise:3'b000, n_launch:0, launches:32'h0,
                first_run:-1, done_cyc:-1, err_cyc:1, fin_step:0};
    vecs[4] = '{name:"runaway", s0:sw(1'b0,2'd1,8'd1), s1:sw(1'b0,2'd1,8'd1), fill:sw(1'b0,2'd1,8'd1),
                mode:3'b100, delay:1, noise:3'b000, n_launch:16, launches:32'h5555_5555,
                first_run:2, done_cyc:-1, err_cyc:65, fin_step:0};
    vecs[5] = '{name:"timeout", s0:sw(1'b1,2'd0,8'd1), s1:'0, fill:'0, mode:3'b010,
                delay:0, noise:3'b000, n_launch:1, launches:32'h0,
                first_run:2, done_cyc:-1, err_cyc:11, fin_step:0};
    vecs[6] = '{name:"bad_sel", s0:sw(1'b1,2'd3,8'd1), s1:'0, fill:'0, mode:3'b001,
                delay:1, noise:3'b000, n_launch:0, launches:32'h0,
                first_run:-1, done_cyc:-1, err_cyc:2, fin_step:0};
    vecs[7] = '{name:"done_at_expiry", s0:sw(1'b1,2'd1,8'd1), s1:'0, fill:'0, mode:3'b001,
                delay:8, noise:3'b000, n_launch:1, launches:32'h1,
                first_run:2, done_cyc:12, err_cyc:-1, fin_step:0};
    vecs[8] = '{name:"done_after_expiry", s0:sw(1'b1,2'd1,8'd1), s1:'0, fill:'0, mode:3'b001,
                delay:9, noise:3'b000, n_launch:1, launches:32'h1,
                first_run:2, done_cyc:-1, err_cyc:11, fin_step:0};

    do_reset();
    check("reset.run", 32'(mod_run_o), 0);
    check("reset.en", 32'(mod_en_o), 0);
    check("reset.busy", 32'(busy_o), 0);
    check("reset.done", 32'(done_o), 0);
    check("reset.err", 32'(err_o), 0);
    check("reset.step", 32'(step_o), 0);

    for (int i = 0; i < 9; i++) run_vec(vecs[i]);

    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("abort.err", 32'(err_o), 0);
    check("abort.busy", 32'(busy_o), 0);
    check("abort.done", 32'(done_o), 0);

    // enable drops for the relaunch cycle; a write while busy must not land
    do_reset();
    prog(1'b0, 4'd0, sw(1'b1, 2'd0, 8'd2));
    en_exp  = '{3'b000, 3'b001, 3'b001, 3'b001, 3'b000, 3'b001};
    run_exp = '{3'b000, 3'b001, 3'b000, 3'b000, 3'b001, 3'b000};
    run_i = 1'b1; mode_i = 3'b001;
    tick();
    run_i = 1'b0; mode_i = '0;
    for (int c = 1; c <= 9; c++) begin
      if (c <= 6) begin
        check($sformatf("relaunch.en_c%0d", c), 32'(mod_en_o), 32'(en_exp[c-1]));
        check($sformatf("relaunch.run_c%0d", c), 32'(mod_run_o), 32'(run_exp[c-1]));
      end
      if (c == 9) check("relaunch.done", 32'(done_o), 1);
      mod_done_i  = (c == 4 || c == 7) ? 3'b001 : 3'b000;
      prog_we_i   = (c == 3);
      prog_tbl_i  = 1'b0;
      prog_addr_i = '0;
      prog_data_i = sw(1'b1, 2'd2, 8'd1);
      tick();
    end
    prog_we_i = 1'b0; mod_done_i = '0;
    run_i = 1'b1; mode_i = 3'b001;
    tick();
    run_i = 1'b0; mode_i = '0;
    tick();
    check("busy_write_dropped.run", 32'(mod_run_o), 32'(3'b001));
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;

    // asynchronous reset in WAIT, then all-zero tables trip the runaway guard
    do_reset();
    prog(1'b0, 4'd0, sw(1'b1, 2'd1, 8'd1));
    run_i = 1'b1; mode_i = 3'b001;
    tick();
    run_i = 1'b0; mode_i = '0;
    tick(); tick();
    check("async.en_before", 32'(mod_en_o), 32'(3'b010));
    check("async.busy_before", 32'(busy_o), 1);
    #2 rst_n_i = 1'b0;
    #1;
    check("async.en", 32'(mod_en_o), 0);
    check("async.busy", 32'(busy_o), 0);
    check("async.err", 32'(err_o), 0);
    #2 rst_n_i = 1'b1;
    tick();
    run_i = 1'b1; mode_i = 3'b001;
    tick();
    run_i = 1'b0; mode_i = '0;
    cyc = 1; saw_run = 1'b0;
    while (!err_o && cyc < 60) begin
      if (mod_run_o != 3'b000) saw_run = 1'b1;
      tick();
      cyc++;
    end
    check("cleared.err_cycle", cyc, 33);
    check("cleared.no_launch", 32'(saw_run), 0);
    check("cleared.step_wrapped", 32'(step_o), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
